// File: rtl/alu_mc_pkg.sv
// -----------------------------------------------------------------------------
// alu_mc_pkg
// Shared definitions for the multi-cycle ALU:
//   - opcode map (8-bit codes, including the optional signed ops),
//   - operand source select codes,
//   - top-level FSM state enum,
//   - iterative unit mode enum.
// Optional feature macro: ALU_MC_SIGNED_EN (the signed opcodes are always
// defined here; only the top decides whether to decode them).
// -----------------------------------------------------------------------------
package alu_mc_pkg;

  // Logic ops
  localparam int OP_AND  = 'h00;
  localparam int OP_NAND = 'h01;
  localparam int OP_OR   = 'h02;
  localparam int OP_NOR  = 'h03;
  localparam int OP_XOR  = 'h04;
  localparam int OP_XNOR = 'h05;
  localparam int OP_NOT  = 'h06;
  // Arithmetic ops
  localparam int OP_ADD  = 'h07;
  localparam int OP_SUB  = 'h08;
  localparam int OP_MUL  = 'h09;
  localparam int OP_DIV  = 'h0A;
  localparam int OP_MOD  = 'h0B;
  // Comparisons (all-ones when true)
  localparam int OP_GT   = 'h0C;
  localparam int OP_GE   = 'h0D;
  localparam int OP_EQ   = 'h0E;
  localparam int OP_NE   = 'h0F;
  localparam int OP_LE   = 'h10;
  localparam int OP_LT   = 'h11;
  // PLC set/reset/store/load
  localparam int OP_S    = 'h1B;
  localparam int OP_R    = 'h1C;
  localparam int OP_ST   = 'h1D;
  localparam int OP_STN  = 'h1E;
  localparam int OP_LD   = 'h1F;
  localparam int OP_LDN  = 'h20;
  // Signed ops (decoded only with ALU_MC_SIGNED_EN)
  localparam int OP_SGT  = 'h21;
  localparam int OP_SLT  = 'h22;
  localparam int OP_SMUL = 'h23;
  localparam int OP_SDIV = 'h24;

  // Operand source select codes
  localparam int SRC_RF   = 0;
  localparam int SRC_BIT  = 1;
  localparam int SRC_WORD = 2;
  localparam int SRC_IMM  = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    IM_MUL = 2'd0,
    IM_DIV = 2'd1,
    IM_MOD = 2'd2
  } iter_mode_t;

endpackage

// File: rtl/alu_iter_unit.sv
// -----------------------------------------------------------------------------
// alu_iter_unit
// Shared iterative engine: shift-add multiplier and restoring divider, one
// bit per clock, WIDTH steps per operation.
// Ports:
//   clk, rst_n   clock / asynchronous active-low reset
//   start        load a, b, mode and begin iterating
//   mode         IM_MUL (low product bits), IM_DIV (quotient), IM_MOD (remainder)
//   a, b         unsigned operands (b != 0 for divide modes)
//   busy         iteration in progress
//   done         high in the last iteration cycle; result is valid then
//   result       value produced by the final step (combinational)
// -----------------------------------------------------------------------------
module alu_iter_unit
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  iter_mode_t       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int CW = $clog2(WIDTH);

  // Registers are shared between the two algorithms:
  //   MUL: r_x accumulator, r_y shifted multiplicand, r_z shifted multiplier
  //   DIV: r_x partial remainder, r_y dividend shifting into quotient, r_z divisor
  iter_mode_t       r_mode;
  logic             r_busy;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_x, r_y, r_z;

  logic [WIDTH-1:0] w_nx, w_ny, w_nz;
  logic [WIDTH:0]   w_shift, w_trial;

  // One algorithm step. For division the trial subtraction is WIDTH+1 bits
  // wide; its top bit set means the divisor did not fit, so the shifted
  // remainder is kept (restoring) and a 0 quotient bit is shifted in.
  always_comb begin
    w_nx    = r_x;
    w_ny    = r_y;
    w_nz    = r_z;
    w_shift = '0;
    w_trial = '0;
    if (r_mode == IM_MUL) begin
      w_nx = r_x + (r_z[0] ? r_y : '0);
      w_ny = r_y << 1;
      w_nz = r_z >> 1;
    end else begin
      w_shift = {r_x, r_y[WIDTH-1]};
      w_trial = w_shift - {1'b0, r_z};
      if (!w_trial[WIDTH]) begin
        w_nx = w_trial[WIDTH-1:0];
        w_ny = {r_y[WIDTH-2:0], 1'b1};
      end else begin
        w_nx = w_shift[WIDTH-1:0];
        w_ny = {r_y[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign busy   = r_busy;
  assign done   = r_busy && (r_count == CW'(WIDTH - 1));
  assign result = (r_mode == IM_DIV) ? w_ny : w_nx;

  // Both algorithms load the same way: clear r_x, a into r_y, b into r_z.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy  <= 1'b0;
      r_mode  <= IM_MUL;
      r_count <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
    end else if (start) begin
      r_busy  <= 1'b1;
      r_mode  <= mode;
      r_count <= '0;
      r_x     <= '0;
      r_y     <= a;
      r_z     <= b;
    end else if (r_busy) begin
      r_x     <= w_nx;
      r_y     <= w_ny;
      r_z     <= w_nz;
      r_count <= r_count + 1'b1;
      if (done) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc
// Multi-cycle ALU for the PLC core datapath. Single-cycle ops produce a
// registered result on the accept edge; MUL/DIV/MOD (B != 0) run WIDTH
// iterations in alu_iter_unit and register the result one edge later.
// Optional feature macro: ALU_MC_SIGNED_EN adds SGT, SLT, SMUL, SDIV.
// Ports:
//   clk, rst_n                      clock / asynchronous active-low reset
//   in_valid, in_ready              request handshake
//   op_code                         operation code
//   source1_choice, source2_choice  operand select (0 rf, 1 bit, 2 word, 3 imm)
//   bit_mem_*, word_mem_*, rf_*, imm_*  operand sources for A and B
//   alu_c_in, alu_b_in              carry / borrow in
//   out_valid, out_ready            result handshake
//   alu_out, alu_c_out, alu_b_out   result and carry / borrow out
//   alu_flag_valid                  carry / borrow meaningful (ADD/SUB)
//   alu_zero, alu_div0              result is zero / divide by zero
// -----------------------------------------------------------------------------
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int IWIDTH  = 8,
  parameter int SOURCES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IWIDTH-1:0]          op_code,
  input  logic [$clog2(SOURCES)-1:0] source1_choice,
  input  logic [$clog2(SOURCES)-1:0] source2_choice,
  input  logic                       bit_mem_a,
  input  logic                       bit_mem_b,
  input  logic [WIDTH-1:0]           word_mem_a,
  input  logic [WIDTH-1:0]           rf_a,
  input  logic [WIDTH-1:0]           imm_a,
  input  logic [WIDTH-1:0]           word_mem_b,
  input  logic [WIDTH-1:0]           rf_b,
  input  logic [WIDTH-1:0]           imm_b,
  input  logic                       alu_c_in,
  input  logic                       alu_b_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           alu_out,
  output logic                       alu_c_out,
  output logic                       alu_b_out,
  output logic                       alu_flag_valid,
  output logic                       alu_zero,
  output logic                       alu_div0
);

  localparam int SW = $clog2(SOURCES);

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_out;
  logic             r_c, r_b, r_fv, r_zero, r_div0, r_neg;

  logic [WIDTH-1:0] w_a, w_b, w_res, w_ia, w_ib, w_fin, w_iter_result;
  logic [WIDTH:0]   w_sum, w_dif;
  logic             w_c, w_bo, w_fv, w_div0, w_iter, w_neg;
  logic             w_accept, w_iter_busy, w_iter_done;
  iter_mode_t       w_mode;

  // Operand A source mux; the bit source is zero-extended.
  always_comb begin
    w_a = rf_a;
    case (source1_choice)
      SW'(SRC_BIT):  w_a = {{(WIDTH-1){1'b0}}, bit_mem_a};
      SW'(SRC_WORD): w_a = word_mem_a;
      SW'(SRC_IMM):  w_a = imm_a;
      default:       w_a = rf_a;
    endcase
  end

  // Operand B source mux.
  always_comb begin
    w_b = rf_b;
    case (source2_choice)
      SW'(SRC_BIT):  w_b = {{(WIDTH-1){1'b0}}, bit_mem_b};
      SW'(SRC_WORD): w_b = word_mem_b;
      SW'(SRC_IMM):  w_b = imm_b;
      default:       w_b = rf_b;
    endcase
  end

  assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {{WIDTH{1'b0}}, alu_c_in};
  assign w_dif = {1'b0, w_a} - {1'b0, w_b} - {{WIDTH{1'b0}}, alu_b_in};

`ifdef ALU_MC_SIGNED_EN
  logic [WIDTH-1:0] w_mag_a, w_mag_b;
  assign w_mag_a = w_a[WIDTH-1] ? -w_a : w_a;
  assign w_mag_b = w_b[WIDTH-1] ? -w_b : w_b;
`endif

  // Decode: single-cycle results are computed straight from the selected
  // operands and registered on the accept edge. Iterative ops only set up
  // the unit's operands/mode; a zero divisor short-circuits to a 1-cycle
  // result. Signed multiply/divide feed magnitudes and remember the sign.
  always_comb begin
    w_res  = w_a;
    w_c    = 1'b0;
    w_bo   = 1'b0;
    w_fv   = 1'b0;
    w_div0 = 1'b0;
    w_iter = 1'b0;
    w_mode = IM_MUL;
    w_ia   = w_a;
    w_ib   = w_b;
    w_neg  = 1'b0;
    case (op_code)
      IWIDTH'(OP_AND):  w_res = w_a & w_b;
      IWIDTH'(OP_NAND): w_res = ~(w_a & w_b);
      IWIDTH'(OP_OR):   w_res = w_a | w_b;
      IWIDTH'(OP_NOR):  w_res = ~(w_a | w_b);
      IWIDTH'(OP_XOR):  w_res = w_a ^ w_b;
      IWIDTH'(OP_XNOR): w_res = ~(w_a ^ w_b);
      IWIDTH'(OP_NOT):  w_res = ~w_a;
      IWIDTH'(OP_ADD): begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_fv  = 1'b1;
      end
      IWIDTH'(OP_SUB): begin
        w_res = w_dif[WIDTH-1:0];
        w_bo  = w_dif[WIDTH];
        w_fv  = 1'b1;
      end
      IWIDTH'(OP_MUL): begin
        w_iter = 1'b1;
        w_mode = IM_MUL;
      end
      IWIDTH'(OP_DIV): begin
        if (w_b == '0) begin
          w_res  = '1;
          w_div0 = 1'b1;
        end else begin
          w_iter = 1'b1;
          w_mode = IM_DIV;
        end
      end
      IWIDTH'(OP_MOD): begin
        if (w_b == '0) begin
          w_res  = w_a;
          w_div0 = 1'b1;
        end else begin
          w_iter = 1'b1;
          w_mode = IM_MOD;
        end
      end
      IWIDTH'(OP_GT):  w_res = {WIDTH{w_a >  w_b}};
      IWIDTH'(OP_GE):  w_res = {WIDTH{w_a >= w_b}};
      IWIDTH'(OP_EQ):  w_res = {WIDTH{w_a == w_b}};
      IWIDTH'(OP_NE):  w_res = {WIDTH{w_a != w_b}};
      IWIDTH'(OP_LE):  w_res = {WIDTH{w_a <= w_b}};
      IWIDTH'(OP_LT):  w_res = {WIDTH{w_a <  w_b}};
      IWIDTH'(OP_S):   w_res = '1;
      IWIDTH'(OP_R):   w_res = '0;
      IWIDTH'(OP_ST), IWIDTH'(OP_LD):   w_res = w_a;
      IWIDTH'(OP_STN), IWIDTH'(OP_LDN): w_res = ~w_a;
`ifdef ALU_MC_SIGNED_EN
      IWIDTH'(OP_SGT): w_res = {WIDTH{$signed(w_a) > $signed(w_b)}};
      IWIDTH'(OP_SLT): w_res = {WIDTH{$signed(w_a) < $signed(w_b)}};
      IWIDTH'(OP_SMUL): begin
        w_iter = 1'b1;
        w_mode = IM_MUL;
        w_ia   = w_mag_a;
        w_ib   = w_mag_b;
        w_neg  = w_a[WIDTH-1] ^ w_b[WIDTH-1];
      end
      IWIDTH'(OP_SDIV): begin
        if (w_b == '0) begin
          w_res  = '1;
          w_div0 = 1'b1;
        end else begin
          w_iter = 1'b1;
          w_mode = IM_DIV;
          w_ia   = w_mag_a;
          w_ib   = w_mag_b;
          w_neg  = w_a[WIDTH-1] ^ w_b[WIDTH-1];
        end
      end
`endif
      default: w_res = w_a;
    endcase
  end

  // A new request may be taken whenever nothing is iterating and any held
  // result is being drained this cycle, which allows back-to-back
  // operation straight out of DONE.
  assign out_valid = (r_state == DONE);
  assign in_ready  = (r_state != ITER) && !w_iter_busy && (!out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;

  alu_iter_unit #(
    .WIDTH (WIDTH)
  ) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (w_accept && w_iter),
    .mode   (w_mode),
    .a      (w_ia),
    .b      (w_ib),
    .busy   (w_iter_busy),
    .done   (w_iter_done),
    .result (w_iter_result)
  );

  // Signed ops ran on magnitudes; restore the sign as the result is stored.
  assign w_fin = r_neg ? -w_iter_result : w_iter_result;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic. An accept from DONE implies out_ready, so the held
  // result is consumed on the same edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_nxt = w_iter ? ITER : DONE;
      ITER: if (w_iter_done) w_state_nxt = DONE;
      DONE: begin
        if (w_accept)       w_state_nxt = w_iter ? ITER : DONE;
        else if (out_ready) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Result and flag registers: loaded on a single-cycle accept or at the
  // end of iteration, otherwise held so DONE presents stable outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_c    <= 1'b0;
      r_b    <= 1'b0;
      r_fv   <= 1'b0;
      r_zero <= 1'b0;
      r_div0 <= 1'b0;
      r_neg  <= 1'b0;
    end else begin
      if (w_accept) r_neg <= w_neg;
      if (w_accept && !w_iter) begin
        r_out  <= w_res;
        r_c    <= w_c;
        r_b    <= w_bo;
        r_fv   <= w_fv;
        r_zero <= (w_res == '0);
        r_div0 <= w_div0;
      end else if ((r_state == ITER) && w_iter_done) begin
        r_out  <= w_fin;
        r_c    <= 1'b0;
        r_b    <= 1'b0;
        r_fv   <= 1'b0;
        r_zero <= (w_fin == '0);
        r_div0 <= 1'b0;
      end
    end
  end

  assign alu_out        = r_out;
  assign alu_c_out      = r_c;
  assign alu_b_out      = r_b;
  assign alu_flag_valid = r_fv;
  assign alu_zero       = r_zero;
  assign alu_div0       = r_div0;

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc
// Self-checking bench for alu_mc (WIDTH=8): directed steps followed by
// random operations, compared against an arithmetic reference model.
// Optional feature macro: ALU_MC_SIGNED_EN (model follows the same define).
// -----------------------------------------------------------------------------
module tb_alu_mc;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op_code;
  logic [1:0] source1_choice, source2_choice;
  logic       bit_mem_a, bit_mem_b;
  logic [7:0] word_mem_a, rf_a, imm_a, word_mem_b, rf_b, imm_b;
  logic       alu_c_in, alu_b_in;
  logic       out_valid, out_ready;
  logic [7:0] alu_out;
  logic       alu_c_out, alu_b_out, alu_flag_valid, alu_zero, alu_div0;

  int checks = 0;
  int errors = 0;
  int expRes, expC, expBo, expFv, expDiv0, expLat;
  int heldRes;

  alu_mc #(.WIDTH(8), .IWIDTH(8), .SOURCES(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .op_code        (op_code),
    .source1_choice (source1_choice),
    .source2_choice (source2_choice),
    .bit_mem_a      (bit_mem_a),
    .bit_mem_b      (bit_mem_b),
    .word_mem_a     (word_mem_a),
    .rf_a           (rf_a),
    .imm_a          (imm_a),
    .word_mem_b     (word_mem_b),
    .rf_b           (rf_b),
    .imm_b          (imm_b),
    .alu_c_in       (alu_c_in),
    .alu_b_in       (alu_b_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .alu_out        (alu_out),
    .alu_c_out      (alu_c_out),
    .alu_b_out      (alu_b_out),
    .alu_flag_valid (alu_flag_valid),
    .alu_zero       (alu_zero),
    .alu_div0       (alu_div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef ALU_MC_SIGNED_EN
  function automatic int toSigned(input int v);
    return (v >= 128) ? v - 256 : v;
  endfunction
`endif

  // Behavioural reference: plain integer arithmetic on 8-bit values.
  // Latency counts edges from the accept edge (inclusive) to out_valid.
  function automatic void refModel(input int op, input int a, input int b,
                                   input int cin, input int bin,
                                   output int res, output int c, output int bo,
                                   output int fv, output int div0, output int lat);
    int t;
    res = a; c = 0; bo = 0; fv = 0; div0 = 0; lat = 1;
    case (op)
      'h00: res = a & b;
      'h01: res = ~(a & b) & 255;
      'h02: res = a | b;
      'h03: res = ~(a | b) & 255;
      'h04: res = a ^ b;
      'h05: res = ~(a ^ b) & 255;
      'h06: res = ~a & 255;
      'h07: begin t = a + b + cin; res = t & 255; c = t / 256; fv = 1; end
      'h08: begin t = a - b - bin; res = t & 255; bo = (t < 0) ? 1 : 0; fv = 1; end
      'h09: begin res = (a * b) & 255; lat = 9; end
      'h0A: if (b == 0) begin res = 255; div0 = 1; end else begin res = a / b; lat = 9; end
      'h0B: if (b == 0) begin res = a; div0 = 1; end else begin res = a % b; lat = 9; end
      'h0C: res = (a >  b) ? 255 : 0;
      'h0D: res = (a >= b) ? 255 : 0;
      'h0E: res = (a == b) ? 255 : 0;
      'h0F: res = (a != b) ? 255 : 0;
      'h10: res = (a <= b) ? 255 : 0;
      'h11: res = (a <  b) ? 255 : 0;
      'h1B: res = 255;
      'h1C: res = 0;
      'h1D, 'h1F: res = a;
      'h1E, 'h20: res = ~a & 255;
`ifdef ALU_MC_SIGNED_EN
      'h21: res = (toSigned(a) > toSigned(b)) ? 255 : 0;
      'h22: res = (toSigned(a) < toSigned(b)) ? 255 : 0;
      'h23: begin res = (toSigned(a) * toSigned(b)) & 255; lat = 9; end
      'h24: if (b == 0) begin res = 255; div0 = 1; end
            else begin res = (toSigned(a) / toSigned(b)) & 255; lat = 9; end
`endif
      default: res = a;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one request's inputs (unused sources get noise) and compute the
  // expected outcome from the effective operands.
  task automatic applyStimulus(input logic [7:0] op, input logic [1:0] s1, input logic [1:0] s2,
                               input logic [7:0] a, input logic [7:0] b,
                               input logic cin, input logic bin);
    int effA, effB;
    rf_a = 8'($urandom); word_mem_a = 8'($urandom); imm_a = 8'($urandom); bit_mem_a = 1'($urandom);
    rf_b = 8'($urandom); word_mem_b = 8'($urandom); imm_b = 8'($urandom); bit_mem_b = 1'($urandom);
    case (s1)
      2'd0: rf_a = a;
      2'd1: bit_mem_a = a[0];
      2'd2: word_mem_a = a;
      default: imm_a = a;
    endcase
    case (s2)
      2'd0: rf_b = b;
      2'd1: bit_mem_b = b[0];
      2'd2: word_mem_b = b;
      default: imm_b = b;
    endcase
    effA = (s1 == 2'd1) ? int'(a[0]) : int'(a);
    effB = (s2 == 2'd1) ? int'(b[0]) : int'(b);
    op_code = op; source1_choice = s1; source2_choice = s2;
    alu_c_in = cin; alu_b_in = bin;
    refModel(int'(op), effA, effB, int'(cin), int'(bin), expRes, expC, expBo, expFv, expDiv0, expLat);
  endtask

  task automatic checkResult(input string tag);
    checkOutput({tag, "_valid"}, int'(out_valid), 1);
    checkOutput({tag, "_out"},   int'(alu_out), expRes);
    checkOutput({tag, "_cout"},  int'(alu_c_out), expC);
    checkOutput({tag, "_bout"},  int'(alu_b_out), expBo);
    checkOutput({tag, "_fv"},    int'(alu_flag_valid), expFv);
    checkOutput({tag, "_zero"},  int'(alu_zero), (expRes == 0) ? 1 : 0);
    checkOutput({tag, "_div0"},  int'(alu_div0), expDiv0);
  endtask

  // Handshake one request (called at a negedge), measure latency, check the
  // result, then spend one more cycle so a ready consumer drains it.
  task automatic doTransaction(input string tag);
    int waited, lat;
    in_valid = 1'b1;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    checkOutput({tag, "_in_ready"}, int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (lat == 3) checkOutput({tag, "_busy_in_ready"}, int'(in_ready), 0);
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, expLat);
    checkResult(tag);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    applyStimulus(8'h00, 2'd0, 2'd0, 8'h00, 8'h00, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("rst_valid", int'(out_valid), 0);
    checkOutput("rst_out",   int'(alu_out), 0);
    checkOutput("rst_flags", int'({alu_c_out, alu_b_out, alu_flag_valid, alu_zero, alu_div0}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(8'h07, 2'd0, 2'd3, 8'hF0, 8'h20, 1'b1, 1'b0);
    doTransaction("add");
    checkOutput("add_literal", int'(alu_out), 'h11);
    applyStimulus(8'h08, 2'd2, 2'd0, 8'h05, 8'h07, 1'b0, 1'b0);
    doTransaction("sub");
    applyStimulus(8'h0E, 2'd0, 2'd2, 8'h3C, 8'h3C, 1'b0, 1'b0);
    doTransaction("eq");
    applyStimulus(8'h0F, 2'd3, 2'd3, 8'h3C, 8'h3C, 1'b0, 1'b0);
    doTransaction("ne");
    applyStimulus(8'h09, 2'd0, 2'd3, 8'h0D, 8'h0B, 1'b0, 1'b0);
    doTransaction("mul");
    checkOutput("mul_literal", int'(alu_out), 'h8F);
    applyStimulus(8'h0A, 2'd0, 2'd0, 8'd200, 8'd7, 1'b0, 1'b0);
    doTransaction("div");
    applyStimulus(8'h0B, 2'd0, 2'd0, 8'd200, 8'd7, 1'b0, 1'b0);
    doTransaction("mod");
    applyStimulus(8'h0A, 2'd0, 2'd3, 8'h55, 8'h00, 1'b0, 1'b0);
    doTransaction("div0");
    applyStimulus(8'h0B, 2'd0, 2'd3, 8'h55, 8'h00, 1'b0, 1'b0);
    doTransaction("mod0");
    applyStimulus(8'h1D, 2'd1, 2'd0, 8'h01, 8'h00, 1'b0, 1'b0);
    doTransaction("st_bit");

    // Backpressure: result held for 5 cycles, then drained with a new request.
    out_ready = 1'b0;
    applyStimulus(8'h07, 2'd0, 2'd0, 8'h12, 8'h34, 1'b0, 1'b0);
    doTransaction("bp_add");
    heldRes = expRes;
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp_hold_out", int'(alu_out), heldRes);
      checkOutput("bp_hold_valid", int'(out_valid), 1);
      checkOutput("bp_hold_in_ready", int'(in_ready), 0);
      @(negedge clk);
    end
    applyStimulus(8'h04, 2'd0, 2'd0, 8'hA5, 8'h0F, 1'b0, 1'b0);
    out_ready = 1'b1;
    in_valid = 1'b1;
    #1 checkOutput("bp_b2b_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checkResult("bp_b2b");
    @(negedge clk);

    // Reset during a divide: outputs clear at once, then a MUL still works.
    applyStimulus(8'h0A, 2'd0, 2'd0, 8'd200, 8'd7, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("rstmid_valid", int'(out_valid), 0);
    checkOutput("rstmid_out", int'(alu_out), 0);
    checkOutput("rstmid_in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    applyStimulus(8'h09, 2'd3, 2'd2, 8'h0D, 8'h0B, 1'b0, 1'b0);
    doTransaction("rstmid_mul");

    // Random operations, including undecoded codes and zero divisors.
    for (int i = 0; i < 40; i++) begin
      applyStimulus(8'($urandom_range(0, 40)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    8'($urandom), (i % 5 == 0) ? 8'h00 : 8'($urandom),
                    1'($urandom), 1'($urandom));
      doTransaction("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
